// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/256 encryption core: one round per clock, key schedule expanded on the fly,
// valid/ready handshakes on both sides.
module aes_cipher_iter #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        datain,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        dataout,
  output logic                busy
);

  localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_cipher_iter: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, r;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, p;
    inv = 8'h01;
    p   = x;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) sr[4*c+rw] = sb[4*((c+rw)%4)+rw];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ rk;
  endfunction

  state_e                state_q, state_d;
  logic [127:0]          blk_q;
  logic [KEY_BITS-1:0]   key_q, key_next;
  logic [7:0]            rcon_q, rcon_next;
  logic [3:0]            round_q;
  logic                  accept, last_round;
  logic                  rot_step, hold_key;
  logic [31:0]           temp_word, nw0, nw1, nw2, nw3;
  logic [127:0]          base_words, round_key, round_out;

  assign accept     = in_valid && in_ready;
  assign last_round = (round_q == 4'(NR));

  // The key window holds the 4 (AES-128) or 8 (AES-256) most recent schedule words, newest last.
  always_comb begin
    base_words = key_q[KEY_BITS-1 -: 128];
    rot_step   = (KEY_BITS == 128) || !round_q[0];
    // AES-256 round 1 uses w4..w7 straight from the loaded key.
    hold_key   = (KEY_BITS == 256) && (round_q == 4'd1);
    temp_word  = rot_step ? (sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0})
                          : sub_word(key_q[31:0]);
    nw0 = base_words[127:96] ^ temp_word;
    nw1 = base_words[95:64] ^ nw0;
    nw2 = base_words[63:32] ^ nw1;
    nw3 = base_words[31:0] ^ nw2;
    if (hold_key) begin
      round_key = key_q[127:0];
      key_next  = key_q;
      rcon_next = rcon_q;
    end else begin
      round_key = {nw0, nw1, nw2, nw3};
      key_next  = KEY_BITS'({key_q, nw0, nw1, nw2, nw3});
      rcon_next = rot_step ? xtime(rcon_q) : rcon_q;
    end
  end

  assign round_out = aes_round(blk_q, round_key, last_round);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRound;
      StRound: if (last_round) state_d = StDone;
      StDone:  if (out_ready) state_d = in_valid ? StRound : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    busy     = (state_q == StRound);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      blk_q  <= datain ^ key[KEY_BITS-1 -: 128];
      key_q  <= key;
      rcon_q <= 8'h01;
    end else if (state_q == StRound) begin
      blk_q  <= round_out;
      key_q  <= key_next;
      rcon_q <= rcon_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q   <= 4'd0;
      out_valid <= 1'b0;
      dataout   <= 128'h0;
    end else begin
      if (accept) round_q <= 4'd1;
      else if (state_q == StRound) round_q <= round_q + 4'd1;

      if ((state_q == StRound) && last_round) begin
        dataout   <= round_out;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed-vector bench for aes_cipher_iter: FIPS-197 vectors, latency, back-to-back, backpressure
// and reset abort, on one AES-128 and one AES-256 instance.
module tb_aes_cipher_iter;

  localparam logic [127:0] KeyA  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         iv_a, ir_a, ov_a, or_a, busy_a;
  logic [127:0] din_a, key_a, dout_a;
  logic         iv_b, ir_b, ov_b, or_b, busy_b;
  logic [127:0] din_b, dout_b;
  logic [255:0] key_b;

  int checks = 0;
  int errors = 0;

  aes_cipher_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .datain(din_a), .key(key_a),
    .out_valid(ov_a), .out_ready(or_a), .dataout(dout_a), .busy(busy_a)
  );

  aes_cipher_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .datain(din_b), .key(key_b),
    .out_valid(ov_b), .out_ready(or_b), .dataout(dout_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One AES-128 block from IDLE, with the sink stalled until completion.
  task automatic run128(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                        input string tag);
    int lat;
    iv_a = 1'b1; din_a = pt; key_a = k; or_a = 1'b0;
    @(posedge clk); #1;
    iv_a = 1'b0; din_a = '0; key_a = '0;
    check({tag, " busy"}, 128'(busy_a), 128'd1);
    check({tag, " in_ready round"}, 128'(ir_a), 128'd0);
    lat = 0;
    while (!ov_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'd10);
    check({tag, " dataout"}, dout_a, ct);
    check({tag, " busy done"}, 128'(busy_a), 128'd0);
    or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    check({tag, " out_valid drop"}, 128'(ov_a), 128'd0);
    check({tag, " idle in_ready"}, 128'(ir_a), 128'd1);
  endtask

  task automatic back_to_back();
    logic [127:0] pts [4];
    logic [127:0] keys [4];
    logic [127:0] cts [4];
    int nin, nout, last_cyc;
    logic acc;
    pts  = '{PtA, PtB, PtA, PtB};
    keys = '{KeyA, KeyB, KeyA, KeyB};
    cts  = '{CtA, CtB, CtA, CtB};
    nin = 0; nout = 0; last_cyc = 0;
    iv_a = 1'b1; or_a = 1'b1; din_a = pts[0]; key_a = keys[0];
    for (int cyc = 0; cyc < 80 && nout < 4; cyc++) begin
      acc = iv_a && ir_a;
      if (ov_a) begin
        check("b2b dataout", dout_a, cts[nout]);
        check("b2b in_ready done", 128'(ir_a), 128'd1);
        if (nout > 0) check("b2b spacing", 128'(cyc - last_cyc), 128'd11);
        last_cyc = cyc;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) begin
        nin++;
        if (nin < 4) begin
          din_a = pts[nin]; key_a = keys[nin];
        end else begin
          iv_a = 1'b0;
        end
      end
    end
    or_a = 1'b0;
    check("b2b block count", 128'(nout), 128'd4);
    check("b2b final idle", 128'(ir_a), 128'd1);
    check("b2b final out_valid", 128'(ov_a), 128'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    iv_a = 1'b0; or_a = 1'b0; din_a = '0; key_a = '0;
    iv_b = 1'b0; or_b = 1'b0; din_b = '0; key_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset out_valid128", 128'(ov_a), 128'd0);
    check("reset dataout128", dout_a, 128'h0);
    check("reset busy128", 128'(busy_a), 128'd0);
    check("reset in_ready128", 128'(ir_a), 128'd1);
    check("reset out_valid256", 128'(ov_b), 128'd0);
    check("reset in_ready256", 128'(ir_b), 128'd1);
    @(posedge clk); #1;

    run128(PtA, KeyA, CtA, "vecA");
    run128(PtB, KeyB, CtB, "vecB");

    // AES-256: left waiting in DONE so a later reset can abort it there.
    iv_b = 1'b1; din_b = PtA; key_b = Key256;
    @(posedge clk); #1;
    iv_b = 1'b0; din_b = '0; key_b = '0;
    lat = 0;
    while (!ov_b && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("aes256 latency", 128'(lat), 128'd14);
    check("aes256 dataout", dout_b, Ct256);

    back_to_back();
    check("aes256 held out_valid", 128'(ov_b), 128'd1);
    check("aes256 held dataout", dout_b, Ct256);
    check("aes256 in_ready stalled", 128'(ir_b), 128'd0);

    // Backpressure: sink stalled for 20 cycles while the source waves new data.
    iv_a = 1'b1; din_a = PtA; key_a = KeyA; or_a = 1'b0;
    @(posedge clk); #1;
    iv_a = 1'b0;
    lat = 0;
    while (!ov_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 128'(lat), 128'd10);
    for (int i = 0; i < 20; i++) begin
      iv_a  = 1'b1;
      din_a = {$urandom, $urandom, $urandom, $urandom};
      key_a = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("bp in_ready", 128'(ir_a), 128'd0);
      @(posedge clk); #1;
      check("bp out_valid", 128'(ov_a), 128'd1);
      check("bp dataout", dout_a, CtA);
    end
    iv_a = 1'b0; or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    check("bp release out_valid", 128'(ov_a), 128'd0);
    check("bp release idle", 128'(ir_a), 128'd1);
    check("bp release busy", 128'(busy_a), 128'd0);
    check("bp dataout kept", dout_a, CtA);

    // Reset while the 128-bit core is in round 5 and the 256-bit core sits in DONE.
    iv_a = 1'b1; din_a = PtB; key_a = KeyB;
    @(posedge clk); #1;
    iv_a = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 128'(busy_a), 128'd0);
    check("abort out_valid", 128'(ov_a), 128'd0);
    check("abort dataout", dout_a, 128'h0);
    check("abort done out_valid256", 128'(ov_b), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort in_ready", 128'(ir_a), 128'd1);
    check("abort in_ready256", 128'(ir_b), 128'd1);
    @(posedge clk); #1;
    run128(PtA, KeyA, CtA, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
